// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with a 2-entry skid buffer and registered in_ready.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble performance counters.
module pipe_stage_elastic #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0,
  parameter int                 CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] main_d, skid_d;
  logic in_fire, out_fire, ld_main, ld_skid, from_skid;
  assign in_ready  = ~state[0];
  assign out_valid = state[1];
  assign out_data  = main_d;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_n   = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_n = in_fire ? ONE : EMPTY;
        ld_main = in_fire;
      end
      ONE: begin
        state_n = in_fire ? (out_fire ? ONE : FULL) : (out_fire ? EMPTY : ONE);
        ld_main = in_fire & out_fire;
        ld_skid = in_fire & ~out_fire;
      end
      FULL: begin
        state_n   = out_fire ? ONE : FULL;
        ld_main   = out_fire;
        from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
    // flush empties the stage but leaves payload registers untouched
    if (flush) begin
      state_n = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_d <= RST_VAL;
      skid_d <= RST_VAL;
    end else begin
      state <= state_n;
      if (ld_main) main_d <= from_skid ? skid_d : in_data;
      if (ld_skid) skid_d <= in_data;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (~out_valid & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed checks of handshake, backpressure, flush, async reset and perf counters.
module tb_pipe_stage_elastic;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  int checks, errors;

  pipe_stage_elastic #(.DATA_W(DATA_W), .RST_VAL(RV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b exp 1", tag, in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid got %b exp 0", tag, out_valid); end
    if (out_data !== RV) begin errors++; $display("FAIL %s out_data got %h exp %h", tag, out_data, RV); end
    if (stall_cnt !== 4'h0) begin errors++; $display("FAIL %s stall_cnt got %h exp 0", tag, stall_cnt); end
    if (bubble_cnt !== 4'h0) begin errors++; $display("FAIL %s bubble_cnt got %h exp 0", tag, bubble_cnt); end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_pre out_valid got %b exp 1", out_valid); end
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    #2 rst = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d out_valid got %b exp 1", i, out_valid); end
      if (out_data !== i) begin errors++; $display("FAIL stream%0d out_data got %h exp %h", i, out_data, i); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d in_ready got %b exp 1", i, in_ready); end
    end
    idle();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full in_ready got %b exp 0", in_ready); end
    if (out_data !== 32'hA) begin errors++; $display("FAIL bp_full out_data got %h exp a", out_data); end
    in_data = 32'hC;
    step();
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold in_ready got %b exp 0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold out_valid got %b exp 1", out_valid); end
    if (out_data !== 32'hA) begin errors++; $display("FAIL bp_hold out_data got %h exp a", out_data); end
    out_ready = 1'b1;
    step();
    checks += 2;
    if (out_data !== 32'hB) begin errors++; $display("FAIL bp_drain1 out_data got %h exp b", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 in_ready got %b exp 1", in_ready); end
    step();
    idle();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain2 out_valid got %b exp 1", out_valid); end
    if (out_data !== 32'hC) begin errors++; $display("FAIL bp_drain2 out_data got %h exp c", out_data); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC; flush = 1'b1;
    step();
    idle();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready got %b exp 1", in_ready); end
    if (out_data !== 32'hA) begin errors++; $display("FAIL flush out_data got %h exp a", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after%0d out_valid got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] e_bub4, e_sat;
    e_bub4 = PERF ? 4'h4 : 4'h0;
    e_sat  = PERF ? 4'hF : 4'h0;
    idle();
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    step(); step(); step();
    in_valid = 1'b1; in_data = 32'h77;
    step();
    idle();
    for (int i = 0; i < 20; i++) step();
    checks += 2;
    if (stall_cnt !== e_sat) begin errors++; $display("FAIL perf_stall got %h exp %h", stall_cnt, e_sat); end
    if (bubble_cnt !== e_bub4) begin errors++; $display("FAIL perf_bubble got %h exp %h", bubble_cnt, e_bub4); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== e_sat) begin errors++; $display("FAIL perf_flush stall got %h exp %h", stall_cnt, e_sat); end
    #3 rst = 1'b1;
    #1 check_reset_outputs("perf_rst");
    #2 rst = 1'b0;
  endtask

  task automatic test_async_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    idle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_pre in_ready got %b exp 0", in_ready); end
    #3 rst = 1'b1;
    #1 check_reset_outputs("arst_full");
    #2 rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h55;
    step();
    idle();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_next out_valid got %b exp 1", out_valid); end
    if (out_data !== 32'h55) begin errors++; $display("FAIL arst_next out_data got %h exp 55", out_data); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12 rst = 1'b0;
    check_reset_outputs("reset_init");
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_perf();
    test_async_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
